// File: rtl/uart_stream_pkg.sv
// -----------------------------------------------------------------------------
// uart_stream_pkg
// Shared constants and types for the framebuffer-to-UART byte streamer:
//   SYNC0/SYNC1 - two sync bytes that open every frame
//   HDR_LEN     - header length in bytes (sync pair + HRes + VRes, big-endian)
//   PIXEL_W     - RGB444 pixel width
//   state_t     - streamer FSM state encoding
//   hdr_byte()  - header byte selected by its index within the header
// -----------------------------------------------------------------------------
package uart_stream_pkg;

    localparam logic [7:0] SYNC0   = 8'hAA;
    localparam logic [7:0] SYNC1   = 8'h55;
    localparam int         HDR_LEN = 6;
    localparam int         PIXEL_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        PACK,
        CSUM,
        END
    } state_t;

    function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                            input logic [15:0] hres,
                                            input logic [15:0] vres);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC0;
            3'd1:    b = SYNC1;
            3'd2:    b = hres[15:8];
            3'd3:    b = hres[7:0];
            3'd4:    b = vres[15:8];
            3'd5:    b = vres[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/vga_frame_uart_streamer_if.sv
// -----------------------------------------------------------------------------
// vga_frame_uart_streamer_if
// Bundles the two data paths of the streamer:
//   framebuffer read port : o_rd_en, o_rd_addr (to memory), i_rd_data (from
//                           memory, valid one cycle after o_rd_en)
//   UART byte handshake   : o_byte_valid, o_byte (to UART), i_uart_ready (from
//                           UART); a byte moves when valid && ready.
// Modports:
//   master - the streamer side
//   slave  - the framebuffer/UART side
// -----------------------------------------------------------------------------
interface vga_frame_uart_streamer_if #(
    parameter int AddrWidth = 15
);

    logic                                 o_rd_en;
    logic [AddrWidth-1:0]                 o_rd_addr;
    logic [uart_stream_pkg::PIXEL_W-1:0]  i_rd_data;
    logic                                 o_byte_valid;
    logic [7:0]                           o_byte;
    logic                                 i_uart_ready;

    modport master (
        output o_rd_en,
        output o_rd_addr,
        input  i_rd_data,
        output o_byte_valid,
        output o_byte,
        input  i_uart_ready
    );

    modport slave (
        input  o_rd_en,
        input  o_rd_addr,
        output i_rd_data,
        input  o_byte_valid,
        input  o_byte,
        output i_uart_ready
    );

endinterface

// File: rtl/rgb444_pair_packer.sv
// -----------------------------------------------------------------------------
// rgb444_pair_packer
// Holds one pixel pair (A, B) and selects one of the three packed bytes:
//   sel 0 : A[11:4]
//   sel 1 : {A[3:0], B[11:8]}
//   sel 2 : B[7:0]
// Ports:
//   CLK, RST   - clock, asynchronous active-low reset
//   cap_a      - load pix into A
//   cap_b      - load pix into B
//   pix        - pixel from the framebuffer read port
//   sel        - packed byte index
//   byte_out   - selected byte (combinational from A/B)
// -----------------------------------------------------------------------------
module rgb444_pair_packer
    import uart_stream_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               cap_a,
    input  logic               cap_b,
    input  logic [PIXEL_W-1:0] pix,
    input  logic [1:0]         sel,
    output logic [7:0]         byte_out
);

    logic [PIXEL_W-1:0] pix_a;
    logic [PIXEL_W-1:0] pix_b;

    // NOTE: these are plain registers, not a memory array, so they take the
    // async reset like every other flop; a RAM would be left unreset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pix_a <= '0;
            pix_b <= '0;
        end else begin
            if (cap_a) pix_a <= pix;
            if (cap_b) pix_b <= pix;
        end
    end

    // NOTE: byte_out gets a value on every path (default first) so no latch
    // is inferred for the unused sel code.
    always_comb begin
        byte_out = 8'h00;
        case (sel)
            2'd0:    byte_out = pix_a[11:4];
            2'd1:    byte_out = {pix_a[3:0], pix_b[11:8]};
            2'd2:    byte_out = pix_b[7:0];
            default: byte_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/vga_frame_uart_streamer.sv
// -----------------------------------------------------------------------------
// vga_frame_uart_streamer
// On a one-cycle i_start, walks the framebuffer in linear order and emits one
// byte frame to the UART: 6-byte header (AA 55 HRes VRes), then every pixel
// pair packed into three bytes, then (optionally) an XOR checksum byte.
// Build option:
//   FRAME_CHECKSUM_EN - when defined, an 8-bit running XOR of all payload bytes
//                       is appended as the final byte of each frame.
// Ports:
//   CLK, RST   - clock, asynchronous active-low reset
//   i_start    - capture request, ignored unless idle
//   o_busy     - high from accepted i_start until the final byte is accepted
//   o_done     - one-cycle pulse after the final byte is accepted
//   bus        - framebuffer read port and UART byte handshake (master side)
// Parameters: HRes, VRes (frame size, HRes*VRes even), AddrWidth.
// -----------------------------------------------------------------------------
module vga_frame_uart_streamer
    import uart_stream_pkg::*;
#(
    parameter int HRes      = 160,
    parameter int VRes      = 120,
    parameter int AddrWidth = $clog2(HRes * VRes)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    vga_frame_uart_streamer_if.master  bus
);

    localparam logic [15:0]          HRES_W    = 16'(HRes);
    localparam logic [15:0]          VRES_W    = 16'(VRes);
    localparam logic [AddrWidth-1:0] LAST_ADDR = AddrWidth'(HRes * VRes - 1);
    localparam logic [AddrWidth-1:0] ADDR_ONE  = AddrWidth'(1);

    state_t     state;
    logic [2:0] cnt;        // byte index in HDR/PACK, cycle index in FETCH
    logic       transfer;
    logic       cap_a;
    logic       cap_b;
    logic [1:0] pack_sel;
    logic [7:0] pack_byte;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] csum;
`endif

    assign transfer = bus.o_byte_valid && bus.i_uart_ready;

    // A is on the read data bus in FETCH cycle 1, B in FETCH cycle 2.
    assign cap_a = (state == FETCH) && (cnt == 3'd1);
    assign cap_b = (state == FETCH) && (cnt == 3'd2);

    // o_byte is registered, so the packer is asked for the byte that will be
    // offered next: byte 0 while leaving FETCH, cnt+1 while in PACK. Byte 0
    // needs only A, which is already held when B is being captured.
    assign pack_sel = (state == PACK) ? 2'(cnt + 3'd1) : 2'd0;

    rgb444_pair_packer u_packer (
        .CLK      (CLK),
        .RST      (RST),
        .cap_a    (cap_a),
        .cap_b    (cap_b),
        .pix      (bus.i_rd_data),
        .sel      (pack_sel),
        .byte_out (pack_byte)
    );

    // NOTE: all state and outputs update with non-blocking assignments so
    // every branch reads the pre-edge values of its neighbours.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state            <= IDLE;
            cnt              <= 3'd0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            bus.o_rd_en      <= 1'b0;
            bus.o_rd_addr    <= '0;
            bus.o_byte_valid <= 1'b0;
            bus.o_byte       <= 8'h00;
`ifdef FRAME_CHECKSUM_EN
            csum             <= 8'h00;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state            <= HDR;
                        cnt              <= 3'd0;
                        o_busy           <= 1'b1;
                        bus.o_byte_valid <= 1'b1;
                        bus.o_byte       <= SYNC0;
`ifdef FRAME_CHECKSUM_EN
                        csum             <= 8'h00;
`endif
                    end
                end

                HDR: begin
                    if (transfer) begin
                        if (cnt == 3'(HDR_LEN - 1)) begin
                            state            <= FETCH;
                            cnt              <= 3'd0;
                            bus.o_byte_valid <= 1'b0;
                            bus.o_rd_en      <= 1'b1;
                        end else begin
                            cnt        <= cnt + 3'd1;
                            bus.o_byte <= hdr_byte(cnt + 3'd1, HRES_W, VRES_W);
                        end
                    end
                end

                FETCH: begin
                    case (cnt)
                        3'd0: begin
                            // Second read of the pair; rd_en stays high.
                            bus.o_rd_addr <= bus.o_rd_addr + ADDR_ONE;
                            cnt           <= 3'd1;
                        end
                        3'd1: begin
                            bus.o_rd_en <= 1'b0;
                            cnt         <= 3'd2;
                        end
                        default: begin
                            state            <= PACK;
                            cnt              <= 3'd0;
                            bus.o_byte_valid <= 1'b1;
                            bus.o_byte       <= pack_byte;
                        end
                    endcase
                end

                PACK: begin
                    if (transfer) begin
`ifdef FRAME_CHECKSUM_EN
                        csum <= csum ^ bus.o_byte;
`endif
                        if (cnt == 3'd2) begin
                            // The address only advances between pairs, so it
                            // stops at the last pixel instead of wrapping.
                            if (bus.o_rd_addr == LAST_ADDR) begin
`ifdef FRAME_CHECKSUM_EN
                                state      <= CSUM;
                                bus.o_byte <= csum ^ bus.o_byte;
`else
                                state            <= END;
                                bus.o_byte_valid <= 1'b0;
                                o_busy           <= 1'b0;
                                o_done           <= 1'b1;
`endif
                            end else begin
                                state            <= FETCH;
                                cnt              <= 3'd0;
                                bus.o_byte_valid <= 1'b0;
                                bus.o_rd_en      <= 1'b1;
                                bus.o_rd_addr    <= bus.o_rd_addr + ADDR_ONE;
                            end
                        end else begin
                            cnt        <= cnt + 3'd1;
                            bus.o_byte <= pack_byte;
                        end
                    end
                end

`ifdef FRAME_CHECKSUM_EN
                CSUM: begin
                    if (transfer) begin
                        state            <= END;
                        bus.o_byte_valid <= 1'b0;
                        o_busy           <= 1'b0;
                        o_done           <= 1'b1;
                    end
                end
`endif

                END: begin
                    state         <= IDLE;
                    cnt           <= 3'd0;
                    bus.o_rd_addr <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_uart_streamer.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_uart_streamer
// Two streamer instances: a 2x1 frame (literal byte check) and a 4x2 frame
// (table of pixel patterns and UART ready patterns). Expected bytes go into a
// per-instance queue when a frame is requested and are popped as the DUT
// transfers bytes. Honours FRAME_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_vga_frame_uart_streamer;

    localparam int HA  = 2;
    localparam int VA  = 1;
    localparam int HB  = 4;
    localparam int VB  = 2;
    localparam int AWA = $clog2(HA * VA);
    localparam int AWB = $clog2(HB * VB);
`ifdef FRAME_CHECKSUM_EN
    localparam int CS  = 1;
`else
    localparam int CS  = 0;
`endif
    localparam int LEN_A = 6 + 3 * HA * VA / 2 + CS;
    localparam int LEN_B = 6 + 3 * HB * VB / 2 + CS;

    typedef logic [7:0][11:0] px_t;
    typedef struct {
        px_t px;
        int  ready_mode;   // 0 always ready, 1 random, 2 random with 50-cycle stalls
        int  exp_len;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, start_a, start_b;
    logic busy_a, busy_b, done_a, done_b;
    logic rdy_b = 1'b1;

    vga_frame_uart_streamer_if #(.AddrWidth(AWA)) bus_a ();
    vga_frame_uart_streamer_if #(.AddrWidth(AWB)) bus_b ();

    assign bus_a.i_uart_ready = 1'b1;
    assign bus_b.i_uart_ready = rdy_b;

    vga_frame_uart_streamer #(.HRes(HA), .VRes(VA), .AddrWidth(AWA)) dut_a (
        .CLK(clk), .RST(rst_a), .i_start(start_a),
        .o_busy(busy_a), .o_done(done_a), .bus(bus_a)
    );

    vga_frame_uart_streamer #(.HRes(HB), .VRes(VB), .AddrWidth(AWB)) dut_b (
        .CLK(clk), .RST(rst_b), .i_start(start_b),
        .o_busy(busy_b), .o_done(done_b), .bus(bus_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- framebuffer models ----------------
    logic [11:0] fb_a [2];
    logic [11:0] fb_b [8];
    int          rd_log_b [$];

    always @(posedge clk) begin
        if (bus_a.o_rd_en) bus_a.i_rd_data <= fb_a[bus_a.o_rd_addr];
        if (bus_b.o_rd_en) begin
            bus_b.i_rd_data <= fb_b[bus_b.o_rd_addr];
            rd_log_b.push_back(int'(bus_b.o_rd_addr));
        end
    end

    // ---------------- UART ready generator for instance B ----------------
    int ready_mode = 0;
    always @(posedge clk) begin : ready_gen
        int stall_left;
        int last_mode;
        #1;
        if (ready_mode == 2 && last_mode != 2) stall_left = 50;
        last_mode = ready_mode;
        case (ready_mode)
            0: rdy_b = 1'b1;
            1: rdy_b = ($urandom_range(0, 2) != 0);
            default: begin
                if (stall_left > 0) begin
                    stall_left--;
                    rdy_b = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    stall_left = 50;
                    rdy_b = 1'b0;
                end else begin
                    rdy_b = 1'($urandom_range(0, 1));
                end
            end
        endcase
    end

    // ---------------- scoreboards / monitors ----------------
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    int bytes_a = 0, bytes_b = 0, done_cnt_a = 0, done_cnt_b = 0;

    always @(negedge clk) begin
        if (rst_a) begin
            if (bus_a.o_byte_valid && bus_a.i_uart_ready) begin
                bytes_a++;
                check("a_busy_during_byte", 32'(busy_a), 32'd1);
                if (exp_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected_byte: got 0x%0h expected no byte", bus_a.o_byte);
                end else begin
                    check("a_byte", 32'(bus_a.o_byte), 32'(exp_a.pop_front()));
                end
            end
            if (done_a) begin
                done_cnt_a++;
                check("a_quiet_at_done", {30'd0, busy_a, bus_a.o_byte_valid}, 32'd0);
            end
        end
    end

    always @(negedge clk or negedge rst_b) begin : mon_b
        logic       hold;
        logic [7:0] held;
        if (!rst_b) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("b_valid_held", 32'(bus_b.o_byte_valid), 32'd1);
                check("b_byte_held", 32'(bus_b.o_byte), 32'(held));
            end
            hold = bus_b.o_byte_valid && !bus_b.i_uart_ready;
            held = bus_b.o_byte;
            if (bus_b.o_byte_valid && bus_b.i_uart_ready) begin
                bytes_b++;
                check("b_busy_during_byte", 32'(busy_b), 32'd1);
                if (exp_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_byte: got 0x%0h expected no byte", bus_b.o_byte);
                end else begin
                    check("b_byte", 32'(bus_b.o_byte), 32'(exp_b.pop_front()));
                end
            end
            if (done_b) begin
                done_cnt_b++;
                check("b_quiet_at_done", {30'd0, busy_b, bus_b.o_byte_valid}, 32'd0);
            end
        end
    end

    // ---------------- reference model for the 4x2 instance ----------------
    function automatic void push_frame_b(input px_t px);
        logic [7:0] cs;
        logic [7:0] p0, p1, p2;
        cs = 8'h00;
        exp_b.push_back(8'hAA);
        exp_b.push_back(8'h55);
        exp_b.push_back(8'h00);
        exp_b.push_back(8'(HB));
        exp_b.push_back(8'h00);
        exp_b.push_back(8'(VB));
        for (int k = 0; k < HB * VB; k += 2) begin
            p0 = px[k][11:4];
            p1 = {px[k][3:0], px[k+1][11:8]};
            p2 = px[k+1][7:0];
            exp_b.push_back(p0);
            exp_b.push_back(p1);
            exp_b.push_back(p2);
            cs = cs ^ p0 ^ p1 ^ p2;
        end
        if (CS != 0) exp_b.push_back(cs);
    endfunction

    function automatic px_t mk_px(input logic [11:0] p0, p1, p2, p3, p4, p5, p6, p7);
        px_t p;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        p[4] = p4; p[5] = p5; p[6] = p6; p[7] = p7;
        return p;
    endfunction

    // ---------------- helpers ----------------
    // Pulses i_start for one cycle and checks the first header byte is
    // offered on the cycle right after the request.
    task automatic pulse_start(input int which);
        @(posedge clk); #1;
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        if (which == 0) begin
            check("a_busy_after_start", 32'(busy_a), 32'd1);
            check("a_first_valid", 32'(bus_a.o_byte_valid), 32'd1);
            check("a_first_byte", 32'(bus_a.o_byte), 32'hAA);
        end else begin
            check("b_busy_after_start", 32'(busy_b), 32'd1);
            check("b_first_valid", 32'(bus_b.o_byte_valid), 32'd1);
            check("b_first_byte", 32'(bus_b.o_byte), 32'hAA);
        end
    endtask

    task automatic wait_done(input int which, input int budget, input string name);
        int  n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            seen = (which == 0) ? done_a : done_b;
            n++;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_bytes_b(input int target, input int budget);
        int n;
        n = 0;
        while (bytes_b < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("b_bytes_reached", 32'(bytes_b >= target), 32'd1);
    endtask

    task automatic run_b(input vec_t v, input string tag);
        int b0, d0, r0;
        for (int i = 0; i < 8; i++) fb_b[i] = v.px[i];
        ready_mode = v.ready_mode;
        b0 = bytes_b;
        d0 = done_cnt_b;
        r0 = rd_log_b.size();
        push_frame_b(v.px);
        pulse_start(1);
        wait_done(1, 20000, {tag, "_done_timeout"});
        @(negedge clk);
        check({tag, "_frame_len"}, 32'(bytes_b - b0), 32'(v.exp_len));
        check({tag, "_done_count"}, 32'(done_cnt_b - d0), 32'd1);
        check({tag, "_busy_after"}, 32'(busy_b), 32'd0);
        check({tag, "_queue_drained"}, 32'(exp_b.size()), 32'd0);
        check({tag, "_read_count"}, 32'(rd_log_b.size() - r0), 32'd8);
        for (int i = 0; i < 8 && r0 + i < rd_log_b.size(); i++)
            check({tag, "_read_addr"}, 32'(rd_log_b[r0 + i]), 32'(i));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    vec_t vecs [4];

    initial begin
        int d0, b0;
        px_t p1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        fb_a[0] = 12'h123;
        fb_a[1] = 12'h456;

        p1 = mk_px(12'h000, 12'hFFF, 12'hA5C, 12'h3C1, 12'h7E2, 12'h19B, 12'h864, 12'hF0F);
        vecs[0] = '{px: p1, ready_mode: 0, exp_len: LEN_B};
        vecs[1] = '{px: p1, ready_mode: 1, exp_len: LEN_B};
        vecs[2] = '{px: p1, ready_mode: 2, exp_len: LEN_B};
        vecs[3] = '{px: mk_px(12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hABC, 12'hDEF, 12'h135, 12'h79B),
                    ready_mode: 1, exp_len: LEN_B};

        // Reset state.
        #12;
        check("rst_busy", 32'(busy_b), 32'd0);
        check("rst_done", 32'(done_b), 32'd0);
        check("rst_rd_en", 32'(bus_b.o_rd_en), 32'd0);
        check("rst_rd_addr", 32'(bus_b.o_rd_addr), 32'd0);
        check("rst_valid", 32'(bus_b.o_byte_valid), 32'd0);
        check("rst_byte", 32'(bus_b.o_byte), 32'd0);
        check("rst_a_valid", 32'(bus_a.o_byte_valid), 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 2x1 frame against literal bytes.
        foreach (exp_a[i]) exp_a.delete(i);
        exp_a = '{8'hAA, 8'h55, 8'h00, 8'h02, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56};
        if (CS != 0) exp_a.push_back(8'h70);
        d0 = done_cnt_a;
        pulse_start(0);
        wait_done(0, 200, "a_done_timeout");
        repeat (5) @(negedge clk);
        check("a_frame_len", 32'(bytes_a), 32'(LEN_A));
        check("a_done_once", 32'(done_cnt_a - d0), 32'd1);
        check("a_busy_after", 32'(busy_a), 32'd0);
        check("a_queue_drained", 32'(exp_a.size()), 32'd0);

        // Table: pixel patterns x ready patterns on the 4x2 instance.
        for (int i = 0; i < 4; i++) run_b(vecs[i], $sformatf("vec%0d", i));

        // Busy guard: a second i_start mid-payload is ignored.
        ready_mode = 0;
        for (int i = 0; i < 8; i++) fb_b[i] = p1[i];
        push_frame_b(p1);
        d0 = done_cnt_b;
        b0 = bytes_b;
        pulse_start(1);
        wait_bytes_b(b0 + 8, 200);
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        check("guard_busy_held", 32'(busy_b), 32'd1);
        wait_done(1, 500, "guard_done_timeout");
        repeat (30) @(negedge clk);
        check("guard_frame_len", 32'(bytes_b - b0), 32'(LEN_B));
        check("guard_done_once", 32'(done_cnt_b - d0), 32'd1);
        check("guard_busy_after", 32'(busy_b), 32'd0);
        check("guard_queue_drained", 32'(exp_b.size()), 32'd0);

        // Reset abort mid-PACK.
        push_frame_b(p1);
        d0 = done_cnt_b;
        b0 = bytes_b;
        pulse_start(1);
        wait_bytes_b(b0 + 7, 200);
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        check("abort_busy", 32'(busy_b), 32'd0);
        check("abort_done", 32'(done_b), 32'd0);
        check("abort_rd_en", 32'(bus_b.o_rd_en), 32'd0);
        check("abort_rd_addr", 32'(bus_b.o_rd_addr), 32'd0);
        check("abort_valid", 32'(bus_b.o_byte_valid), 32'd0);
        check("abort_byte", 32'(bus_b.o_byte), 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        exp_b.delete();
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(done_cnt_b - d0), 32'd0);
        check("abort_no_bytes", 32'(bus_b.o_byte_valid), 32'd0);
        run_b(vecs[0], "after_abort");

        // Back-to-back: second start on the cycle after o_done.
        ready_mode = 0;
        push_frame_b(p1);
        push_frame_b(p1);
        d0 = done_cnt_b;
        b0 = bytes_b;
        pulse_start(1);
        wait_done(1, 500, "b2b_first_done_timeout");
        pulse_start(1);
        wait_done(1, 500, "b2b_second_done_timeout");
        @(negedge clk);
        check("b2b_done_count", 32'(done_cnt_b - d0), 32'd2);
        check("b2b_total_len", 32'(bytes_b - b0), 32'(2 * LEN_B));
        check("b2b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
